// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
//
// Contents:
//   md_state_e     - mult/div unit tracking state {RUN, MD_BUSY}
//   hazard_e       - which hazard rule wins in a given cycle
//   MD_LATENCY_DEF - default mult/div busy time in cycles
//   STALL_CNT_W    - width of the performance stall counter
//   load_use_hit() - load-use dependency test between EX load and ID sources
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   typedef enum logic [2:0] {
      HzNone,
      HzBranch,
      HzLoadUse,
      HzMdBusy,
      HzJump
   } hazard_e;

   localparam int unsigned MD_LATENCY_DEF = 32;
   localparam int unsigned STALL_CNT_W    = 16;

   // A load into $0 never creates a dependency: $0 reads are hardwired zero.
   function automatic logic load_use_hit(input logic       mem_read,
                                         input logic [4:0] ex_rt,
                                         input logic [4:0] id_rs,
                                         input logic [4:0] id_rt,
                                         input logic       id_use_rt);
      logic hit;
      hit = 1'b0;
      if (mem_read && (ex_rt != 5'd0)) begin
         hit = (ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt));
      end
      return hit;
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Busy tracker for the multi-cycle mult/div unit.
//
// A start pulse sampled in RUN loads the down-counter with MD_LATENCY-1 and moves to
// MD_BUSY; busy then stays high for exactly MD_LATENCY cycles. Starts seen while busy are
// ignored (the hazard controller stalls new issue while busy).
//
// Ports:
//   clk   in  pipeline clock, rising edge
//   reset in  asynchronous active-low reset
//   start in  mult/div instruction issuing from EX this cycle
//   busy  out unit busy (state == MD_BUSY)
module md_busy_timer
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy
);

   localparam int unsigned CntW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(MD_LATENCY - 1);

   md_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (start) begin
               cnt_d   = CntLoad;
               state_d = MD_BUSY;
            end
         end
         MD_BUSY: begin
            if (cnt_q == '0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall/flush sequencing for the five-stage MIPS pipeline.
//
// Resolves, in priority order: taken branch in EX (flush IF/ID and ID/EX, overrides any
// stall), load-use dependency (1-cycle stall + bubble), mult/div busy with a HI/LO read or
// new mult/div in ID (stall + bubble), jump in ID (flush IF/ID). Also counts stall cycles
// (PC_Write low) in a saturating 16-bit counter.
//
// Build option: define MULDIV_EN to include the mult/div busy tracker and its stall rule.
// Without it MD_Busy is 0 and the HI/LO / mult/div inputs are ignored.
//
// Ports:
//   clk, reset              clock (rising) / asynchronous active-low reset
//   IF_ID_Rs, IF_ID_Rt      ID-stage source registers
//   IF_ID_UseRt             ID instruction reads Rt
//   IF_ID_ReadHiLo          ID instruction is mfhi/mflo
//   IF_ID_MulDiv            ID instruction is mult/div
//   ID_Jump                 jump resolved in ID
//   ID_EX_MemRead, ID_EX_Rt load in EX and its destination
//   ID_EX_MulDiv            mult/div in EX, issuing this cycle
//   EX_BranchTaken          taken branch resolved in EX
//   PC_Write, IF_ID_Write   register write enables
//   IF_ID_Flush, ID_EX_Flush flush/bubble controls
//   MD_Busy                 mult/div unit busy
//   Stall_Count             saturating count of PC_Write=0 cycles
module hazard_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             IF_ID_Rs,
   input  logic [4:0]             IF_ID_Rt,
   input  logic                   IF_ID_UseRt,
   input  logic                   IF_ID_ReadHiLo,
   input  logic                   IF_ID_MulDiv,
   input  logic                   ID_Jump,
   input  logic                   ID_EX_MemRead,
   input  logic [4:0]             ID_EX_Rt,
   input  logic                   ID_EX_MulDiv,
   input  logic                   EX_BranchTaken,
   output logic                   PC_Write,
   output logic                   IF_ID_Write,
   output logic                   IF_ID_Flush,
   output logic                   ID_EX_Flush,
   output logic                   MD_Busy,
   output logic [STALL_CNT_W-1:0] Stall_Count
);

   logic    md_busy;
   logic    load_use;
   logic    md_hazard;
   hazard_e hazard;

   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

`ifdef MULDIV_EN
   md_busy_timer #(
      .MD_LATENCY(MD_LATENCY)
   ) u_md_busy_timer (
      .clk  (clk),
      .reset(reset),
      .start(ID_EX_MulDiv),
      .busy (md_busy)
   );

   assign md_hazard = md_busy && (IF_ID_ReadHiLo || IF_ID_MulDiv);
`else
   logic unused_md_inputs;
   assign unused_md_inputs = ^{IF_ID_ReadHiLo, IF_ID_MulDiv, ID_EX_MulDiv};
   assign md_busy          = 1'b0;
   assign md_hazard        = 1'b0;
`endif

   assign MD_Busy  = md_busy;
   assign load_use = load_use_hit(ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UseRt);

   // Priority select. A taken branch wins over any stall since the stalled ID instruction
   // is squashed by the flush anyway.
   always_comb begin
      hazard = HzNone;
      if (EX_BranchTaken) begin
         hazard = HzBranch;
      end else if (load_use) begin
         hazard = HzLoadUse;
      end else if (md_hazard) begin
         hazard = HzMdBusy;
      end else if (ID_Jump) begin
         hazard = HzJump;
      end
   end

   always_comb begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      unique case (hazard)
         HzBranch: begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
         end
         HzLoadUse, HzMdBusy: begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
         end
         HzJump: begin
            IF_ID_Flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!PC_Write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MD_LATENCY = 4), directed steps plus a
// randomized phase compared against a behavioural model of the hazard rules.
module tb_hazard_stall_ctrl;

   localparam int unsigned Lat = 4;
`ifdef MULDIV_EN
   localparam bit MdEn = 1'b1;
`else
   localparam bit MdEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  if_rs, if_rt, ex_rt;
   logic        use_rt, rd_hilo, id_md, jump, mem_read, ex_md, br;
   logic        pc_write, ifid_write, ifid_flush, idex_flush, md_busy;
   logic [15:0] stall_count;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .MD_LATENCY(Lat)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .IF_ID_Rs      (if_rs),
      .IF_ID_Rt      (if_rt),
      .IF_ID_UseRt   (use_rt),
      .IF_ID_ReadHiLo(rd_hilo),
      .IF_ID_MulDiv  (id_md),
      .ID_Jump       (jump),
      .ID_EX_MemRead (mem_read),
      .ID_EX_Rt      (ex_rt),
      .ID_EX_MulDiv  (ex_md),
      .EX_BranchTaken(br),
      .PC_Write      (pc_write),
      .IF_ID_Write   (ifid_write),
      .IF_ID_Flush   (ifid_flush),
      .ID_EX_Flush   (idex_flush),
      .MD_Busy       (md_busy),
      .Stall_Count   (stall_count)
   );

   int unsigned passed = 0;
   int unsigned total  = 0;

   // Reference model state: remaining busy cycles of the mult/div unit, stall total.
   int unsigned m_rem = 0;
   int unsigned m_stalls = 0;
   bit e_pcw, e_ifw, e_iff, e_ief;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_inputs();
      if_rs = 0; if_rt = 0; ex_rt = 0;
      use_rt = 0; rd_hilo = 0; id_md = 0; jump = 0; mem_read = 0; ex_md = 0; br = 0;
   endtask

   function automatic bit m_busy();
      return MdEn && (m_rem > 0);
   endfunction

   task automatic model_outputs();
      bit dep, md_stall;
      dep = mem_read && (ex_rt != 0) &&
            ((ex_rt == if_rs) || (use_rt && (ex_rt == if_rt)));
      md_stall = m_busy() && (rd_hilo || id_md);
      if (br)                   {e_pcw, e_ifw, e_iff, e_ief} = 4'b1111;
      else if (dep || md_stall) {e_pcw, e_ifw, e_iff, e_ief} = 4'b0001;
      else if (jump)            {e_pcw, e_ifw, e_iff, e_ief} = 4'b1110;
      else                      {e_pcw, e_ifw, e_iff, e_ief} = 4'b1100;
   endtask

   // Called at posedge+1 with inputs settled: check mid-cycle, then advance one edge.
   task automatic step(input string tag);
      #4;
      model_outputs();
      check({tag, ".pcw"}, pc_write, e_pcw);
      check({tag, ".ifw"}, ifid_write, e_ifw);
      check({tag, ".iff"}, ifid_flush, e_iff);
      check({tag, ".ief"}, idex_flush, e_ief);
      check({tag, ".busy"}, md_busy, m_busy());
      check({tag, ".cnt"}, stall_count, m_stalls);
      @(posedge clk);
      if (!e_pcw && m_stalls < 16'hFFFF) m_stalls++;
      if (m_rem > 0) m_rem--;
      else if (MdEn && ex_md) m_rem = Lat;
      #1;
   endtask

   initial begin
      int unsigned sc0;
      clear_inputs();
      reset = 1'b0;
      #12;
      check("rst.cnt", stall_count, 0);
      check("rst.busy", md_busy, 0);
      check("rst.pcw", pc_write, 1);
      reset = 1'b1;
      @(posedge clk); #1;

      // Load-use on Rs: one stall cycle, counter 0 -> 1.
      mem_read = 1; ex_rt = 8; if_rs = 8;
      step("lu");
      check("lu.cnt1", stall_count, 1);
      clear_inputs();
      step("lu.after");

      // $0 load and Rt gating.
      mem_read = 1; ex_rt = 0; if_rs = 0;
      step("zero");
      mem_read = 1; ex_rt = 9; if_rt = 9; if_rs = 3; use_rt = 0;
      step("rtgate");
      use_rt = 1;
      step("rtuse");

      // Branch overrides the load-use stall.
      sc0 = m_stalls;
      mem_read = 1; ex_rt = 8; if_rs = 8; use_rt = 0; if_rt = 0; br = 1;
      step("brov");
      check("brov.cnt", stall_count, sc0);
      clear_inputs();
      jump = 1;
      step("jump");
      clear_inputs();

      // Mult/div issue followed by an mflo held in ID.
      sc0 = m_stalls;
      ex_md = 1;
      step("md.issue");
      ex_md = 0; rd_hilo = 1;
      for (int i = 0; i < int'(Lat); i++) step("md.wait");
      step("md.go");
      check("md.stalls", stall_count - sc0, MdEn ? Lat : 0);
      clear_inputs();

      // Asynchronous reset while busy (counter at 2).
      ex_md = 1;
      step("mr.issue");
      ex_md = 0;
      step("mr.b1");
      reset = 1'b0;
      #1;
      check("mr.busy", md_busy, 0);
      check("mr.cnt", stall_count, 0);
      m_rem = 0; m_stalls = 0;
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;
      rd_hilo = 1;
      step("mr.mflo");
      check("mr.pcw", pc_write, 1);
      clear_inputs();

      // Randomized phase, small register space so dependencies are frequent.
      for (int i = 0; i < 400; i++) begin
         if_rs    = 5'($urandom_range(0, 3));
         if_rt    = 5'($urandom_range(0, 3));
         ex_rt    = 5'($urandom_range(0, 3));
         use_rt   = 1'($urandom_range(0, 1));
         mem_read = 1'($urandom_range(0, 1));
         br       = ($urandom_range(0, 5) == 0);
         jump     = ($urandom_range(0, 3) == 0);
         rd_hilo  = ($urandom_range(0, 2) == 0);
         id_md    = ($urandom_range(0, 5) == 0);
         ex_md    = ($urandom_range(0, 7) == 0);
         step("rnd");
      end
      clear_inputs();

      // Saturation: hold a load-use stall far past the counter range.
      mem_read = 1; ex_rt = 5; if_rs = 5;
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      m_rem = 0; m_stalls = 16'hFFFF;
      check("sat.cnt", stall_count, 16'hFFFF);
      step("sat.hold");
      check("sat.cnt2", stall_count, 16'hFFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller for the five-stage MIPS core; it works alongside the EX-stage forwarding unit. It detects hazards that forwarding cannot resolve and sequences the stall and flush controls for the PC, IF/ID and ID/EX registers:
- load-use hazards;
- branch and jump control hazards;
- HI/LO reads and new mult/div issue while a multi-cycle mult/div unit is still busy.

It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MD_LATENCY, 32: number of cycles the mult/div unit is busy after issue. Must be ≥2. The counter width is $clog2(MD_LATENCY).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IF_ID_Rs, IF_ID_Rt  in  5  source register numbers of the instruction in ID.
- IF_ID_UseRt  in  1  the ID instruction reads Rt as a source.
- IF_ID_ReadHiLo  in  1  the ID instruction is mfhi/mflo.
- IF_ID_MulDiv  in  1  the ID instruction is mult/multu/div/divu.
- ID_Jump  in  1  a jump is resolved in ID.
- ID_EX_MemRead  in  1  the EX instruction is a load.
- ID_EX_Rt  in  5  destination register of the load in EX.
- ID_EX_MulDiv  in  1  a mult/div instruction is in EX; it issues to the unit this cycle.
- EX_BranchTaken  in  1  a branch is resolved taken in EX.
- PC_Write  out  1  enables the PC update.
- IF_ID_Write  out  1  enables the IF/ID register.
- IF_ID_Flush  out  1  zeroes IF/ID at the next edge.
- ID_EX_Flush  out  1  inserts a bubble into ID/EX at the next edge.
- MD_Busy  out  1  the mult/div unit is busy.
- Stall_Count  out  16  number of cycles with PC_Write=0; saturates.

## Operation
- Stall/flush outputs are combinational from the inputs and the registered state. They are evaluated in strict priority order.

Priority 1 — branch taken:
- Condition: EX_BranchTaken=1.
- Outputs: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1.
- This overrides every stall, because the stalled instruction is squashed anyway.

Priority 2 — load-use:
- Condition: ID_EX_MemRead=1 and ID_EX_Rt≠0, and either ID_EX_Rt==IF_ID_Rs or (IF_ID_UseRt=1 and ID_EX_Rt==IF_ID_Rt).
- Outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.

Priority 3 — mult/div busy:
- Condition: MD_Busy=1 and (IF_ID_ReadHiLo=1 or IF_ID_MulDiv=1).
- Outputs: same as load-use.

Priority 4 — jump:
- Condition: ID_Jump=1.
- Outputs: IF_ID_Flush=1 only.

Default:
- PC_Write=1, IF_ID_Write=1, both flushes 0.

Mult/div FSM, states RUN and MD_BUSY:
- RUN, with ID_EX_MulDiv=1: load md_cnt←MD_LATENCY−1 and go to MD_BUSY.
- MD_BUSY: if md_cnt==0, go to RUN; otherwise md_cnt←md_cnt−1. ID_EX_MulDiv is ignored in this state; issue is prevented by the priority-3 stall.
- MD_Busy = (state==MD_BUSY).
- A taken branch does not cancel an issued mult/div.

Stall_Count:
- Increments on every edge where PC_Write=0.
- Holds at 16'hFFFF.

## Timing
- Stall/flush decisions take effect at the same clock edge; there is no added latency.
- Each load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and forwarding covers the dependency.
- MD_Busy rises 1 cycle after the edge that samples ID_EX_MulDiv=1 and stays high for exactly MD_LATENCY cycles.
- An ID instruction that reads HI/LO issues on the first cycle with MD_Busy=0.
- Load-use and MD-busy conditions in the same cycle produce a single stall cycle; the MD stall continues afterwards.
- Asynchronous reset (reset=0), including mid-mult/div:
  - state←RUN, md_cnt←0, Stall_Count←0.
  - MD_Busy=0 immediately.
  - Combinational outputs follow the priority logic evaluated in RUN.

## Configuration
- MULDIV_EN defined:
  - the mult/div FSM and the priority-3 stall are compiled in.
- MULDIV_EN undefined:
  - no FSM or counter is built.
  - MD_Busy is tied to 0.
  - IF_ID_ReadHiLo, IF_ID_MulDiv and ID_EX_MulDiv are ignored.
  - MD_LATENCY has no effect.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum {RUN, MD_BUSY};
  - the MD_LATENCY default;
  - the STALL_CNT_W=16 constant.
- Sub-module md_busy_timer contains the FSM and down-counter.
  - Inputs: clk, reset, start.
  - Output: busy.
  - It is instantiated only under MULDIV_EN.

## Test plan
- Load-use: lw $8 in EX (ID_EX_MemRead=1, ID_EX_Rt=8) with IF_ID_Rs=8 → one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; Stall_Count goes 0→1.
- $0 load and Rt gating:
  - ID_EX_Rt=0 with IF_ID_Rs=0 → no stall.
  - ID_EX_Rt=9 with IF_ID_Rt=9 and IF_ID_UseRt=0 → no stall.
- Branch over stall: load-use condition together with EX_BranchTaken=1 → PC_Write=1, both flushes 1, Stall_Count unchanged.
- Mult/div (MD_LATENCY=4): ID_EX_MulDiv pulse → MD_Busy high for exactly 4 cycles. An mflo held in ID stalls 4 cycles and issues on cycle 5; Stall_Count=4.
- Reset mid-operation: assert reset during MD_BUSY with md_cnt=2 → MD_Busy=0 and Stall_Count=0 immediately; after release, an mflo in ID does not stall.
- Saturation: force PC_Write=0 for 65,540 cycles → Stall_Count holds at 16'hFFFF.
